// File: rtl/m_chk_redirect.sv
`default_nettype none
// ============================================================================
// Module   : m_chk_redirect
// Purpose  : MEM-stage load-conditional redirect unit. Extracts a word, half
//            or byte lane from the data-memory read word and sign-extends it.
//            It evaluates one of eight compare modes and registers the result
//            one cycle after accept. A taken check raises a held redirect
//            request to fetch (valid/ready); the stage is back-pressured
//            until fetch takes it. A saturating counter records taken checks.
// Ports    : clk, reset (async, active-high)
//            in_valid / in_ready      - instruction handshake
//            chk_op, chk_size, addr_lo, dm_out, m_cmp, m_rt, m_pc8 - operands
//            flush                    - cancels pending redirect and result
//            out_valid, out_taken, out_npc - one-cycle registered result
//            redir_valid / redir_ready, redir_target - redirect request
//            taken_cnt                - saturating taken-check count
// Revision : 1.0  initial parametrised release
// ============================================================================
module m_chk_redirect #(
    parameter int WIDTH  = 32,
    parameter int LANE_W = $clog2(WIDTH / 8),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        chk_op,
    input  logic [1:0]        chk_size,
    input  logic [LANE_W-1:0] addr_lo,
    input  logic [WIDTH-1:0]  dm_out,
    input  logic [WIDTH-1:0]  m_cmp,
    input  logic [WIDTH-1:0]  m_rt,
    input  logic [WIDTH-1:0]  m_pc8,
    input  logic              flush,
    output logic              out_valid,
    output logic              out_taken,
    output logic [WIDTH-1:0]  out_npc,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [WIDTH-1:0]  redir_target,
    output logic [CNT_W-1:0]  taken_cnt
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_OP_NONE = 3'd0;
    localparam logic [2:0] c_OP_GEZ  = 3'd1;
    localparam logic [2:0] c_OP_LTZ  = 3'd2;
    localparam logic [2:0] c_OP_EQZ  = 3'd3;
    localparam logic [2:0] c_OP_NEZ  = 3'd4;
    localparam logic [2:0] c_OP_GTZ  = 3'd5;
    localparam logic [2:0] c_OP_LEZ  = 3'd6;
    localparam logic [2:0] c_OP_EQ   = 3'd7;

    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_BYTE = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic             r_out_valid;
    logic             r_out_taken;
    logic [WIDTH-1:0] r_out_npc;
    logic             r_redir_valid;
    logic [WIDTH-1:0] r_redir_target;
    logic [CNT_W-1:0] r_taken_cnt;

    // ------------------------------------------------------------------------
    // Lane extraction (little-endian) with sign extension
    // ------------------------------------------------------------------------
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_byte_sx;
    logic [WIDTH-1:0] w_half_sx;
    logic [WIDTH-1:0] w_word_sx;
    logic [WIDTH-1:0] w_v;

    assign w_byte    = dm_out[{addr_lo, 3'b000} +: 8];
    assign w_half    = dm_out[{addr_lo[LANE_W-1:1], 4'b0000} +: 16];
    assign w_byte_sx = {{(WIDTH-8){w_byte[7]}}, w_byte};
    assign w_half_sx = {{(WIDTH-16){w_half[15]}}, w_half};

    // A "word" is 32 bits: on a 64-bit datapath it is one of two halves of
    // the read word and must itself be sign-extended; on 32 bits it is the
    // whole word and addr_lo plays no part.
    generate
        if (WIDTH == 64) begin : g_word64
            logic [31:0] w_word;
            assign w_word    = dm_out[{addr_lo[LANE_W-1], 5'b00000} +: 32];
            assign w_word_sx = {{(WIDTH-32){w_word[31]}}, w_word};
        end else begin : g_word32
            assign w_word_sx = dm_out;
        end
    endgenerate

    always_comb begin
        w_v = w_word_sx;                     // size 0 and 3 both mean word
        case (chk_size)
            c_SIZE_HALF: w_v = w_half_sx;
            c_SIZE_BYTE: w_v = w_byte_sx;
            default:     w_v = w_word_sx;
        endcase
    end

    // ------------------------------------------------------------------------
    // Compare modes
    // ------------------------------------------------------------------------
    logic w_neg;
    logic w_zero;
    logic w_taken;

    assign w_neg  = w_v[WIDTH-1];
    assign w_zero = (w_v == '0);

    always_comb begin
        w_taken = 1'b0;
        case (chk_op)
            c_OP_NONE: w_taken = 1'b0;
            c_OP_GEZ:  w_taken = !w_neg;
            c_OP_LTZ:  w_taken = w_neg;
            c_OP_EQZ:  w_taken = w_zero;
            c_OP_NEZ:  w_taken = !w_zero;
            c_OP_GTZ:  w_taken = !w_neg && !w_zero;
            c_OP_LEZ:  w_taken = w_neg || w_zero;
            c_OP_EQ:   w_taken = (w_v == m_cmp);
            default:   w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Handshake. A pending redirect blocks new ops unless fetch takes it this
    // cycle, so a held in_valid is accepted exactly once.
    // ------------------------------------------------------------------------
    logic w_in_ready;
    logic w_accept;

    assign w_in_ready = !r_redir_valid || redir_ready;
    assign w_accept   = in_valid && w_in_ready && !flush;

    // ------------------------------------------------------------------------
    // Result, redirect and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_out_taken    <= 1'b0;
            r_out_npc      <= '0;
            r_redir_valid  <= 1'b0;
            r_redir_target <= '0;
            r_taken_cnt    <= '0;
        end else if (flush) begin
            // Flush kills the result pulse and any pending redirect; the
            // counter only ever reflects ops that were really accepted.
            r_out_valid   <= 1'b0;
            r_redir_valid <= 1'b0;
        end else begin
            r_out_valid <= w_accept;

            if (w_accept) begin
                r_out_taken <= w_taken;
                r_out_npc   <= w_taken ? m_rt : m_pc8;
            end

            // A new taken op wins over the retiring request, so a redirect
            // handed off this cycle is immediately replaced by the next one.
            if (w_accept && w_taken) begin
                r_redir_valid  <= 1'b1;
                r_redir_target <= m_rt;
            end else if (redir_ready) begin
                r_redir_valid  <= 1'b0;
            end

            if (w_accept && w_taken && (r_taken_cnt != c_CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_taken    = r_out_taken;
    assign out_npc      = r_out_npc;
    assign redir_valid  = r_redir_valid;
    assign redir_target = r_redir_target;
    assign taken_cnt    = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_m_chk_redirect.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_chk_redirect
// Purpose  : Directed, self-checking bench for m_chk_redirect. A default
//            instance (CNT_W=16) and a CNT_W=2 instance share all inputs so
//            counter saturation is seen alongside the main behaviour.
// Revision : 1.0  initial release
// ============================================================================
module tb_m_chk_redirect;

    localparam int WIDTH  = 32;
    localparam int LANE_W = 2;

    localparam logic [2:0] c_NONE = 3'd0;
    localparam logic [2:0] c_GEZ  = 3'd1;
    localparam logic [2:0] c_LTZ  = 3'd2;
    localparam logic [2:0] c_EQZ  = 3'd3;
    localparam logic [2:0] c_NEZ  = 3'd4;
    localparam logic [2:0] c_GTZ  = 3'd5;
    localparam logic [2:0] c_LEZ  = 3'd6;
    localparam logic [2:0] c_EQ   = 3'd7;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [2:0]        chk_op;
    logic [1:0]        chk_size;
    logic [LANE_W-1:0] addr_lo;
    logic [WIDTH-1:0]  dm_out;
    logic [WIDTH-1:0]  m_cmp;
    logic [WIDTH-1:0]  m_rt;
    logic [WIDTH-1:0]  m_pc8;
    logic              flush;
    logic              redir_ready;

    logic              in_ready,    in_ready_s;
    logic              out_valid,   out_valid_s;
    logic              out_taken,   out_taken_s;
    logic [WIDTH-1:0]  out_npc,     out_npc_s;
    logic              redir_valid, redir_valid_s;
    logic [WIDTH-1:0]  redir_target, redir_target_s;
    logic [15:0]       taken_cnt;
    logic [1:0]        taken_cnt_s;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_cnt;

    m_chk_redirect #(.WIDTH(WIDTH), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .chk_op(chk_op), .chk_size(chk_size), .addr_lo(addr_lo),
        .dm_out(dm_out), .m_cmp(m_cmp), .m_rt(m_rt), .m_pc8(m_pc8),
        .flush(flush), .out_valid(out_valid), .out_taken(out_taken),
        .out_npc(out_npc), .redir_valid(redir_valid),
        .redir_ready(redir_ready), .redir_target(redir_target),
        .taken_cnt(taken_cnt)
    );

    m_chk_redirect #(.WIDTH(WIDTH), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .chk_op(chk_op), .chk_size(chk_size), .addr_lo(addr_lo),
        .dm_out(dm_out), .m_cmp(m_cmp), .m_rt(m_rt), .m_pc8(m_pc8),
        .flush(flush), .out_valid(out_valid_s), .out_taken(out_taken_s),
        .out_npc(out_npc_s), .redir_valid(redir_valid_s),
        .redir_ready(redir_ready), .redir_target(redir_target_s),
        .taken_cnt(taken_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed table: op, size, lane, read word, expected taken.
    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [1:0]  lane;
        logic [31:0] dm;
        logic        taken;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{c_GTZ,  2'd1, 2'd2, 32'h7FFF_0001, 1'b1}; // half 0x7FFF
        tbl[1] = '{c_LEZ,  2'd1, 2'd2, 32'h7FFF_0001, 1'b0};
        tbl[2] = '{c_LEZ,  2'd2, 2'd0, 32'h7FFF_0000, 1'b1}; // byte 0x00
        tbl[3] = '{c_NEZ,  2'd2, 2'd0, 32'h7FFF_0000, 1'b0};
        tbl[4] = '{c_NONE, 2'd0, 2'd0, 32'hFFFF_FFFF, 1'b0};
        tbl[5] = '{c_GTZ,  2'd3, 2'd0, 32'h8000_0000, 1'b0}; // size 3 = word
        tbl[6] = '{c_EQZ,  2'd1, 2'd0, 32'hFFFF_0000, 1'b1}; // low half 0
        tbl[7] = '{c_GEZ,  2'd2, 2'd2, 32'h0080_0000, 1'b0}; // byte 0x80

        reset = 1'b1; in_valid = 1'b0; chk_op = c_NONE; chk_size = 2'd0;
        addr_lo = '0; dm_out = '0; m_cmp = '0; m_rt = '0; m_pc8 = '0;
        flush = 1'b0; redir_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_redir_valid", {63'd0, redir_valid}, 64'd0);
        chk("rst_cnt", {48'd0, taken_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Byte lane 1 of 0x8000 is 0x80 (negative): GEZ not taken
        dm_out = 32'h0000_8000; chk_size = 2'd2; addr_lo = 2'd1;
        m_rt = 32'h3000; m_pc8 = 32'h3008; chk_op = c_GEZ; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("gez_valid", {63'd0, out_valid}, 64'd1);
        chk("gez_taken", {63'd0, out_taken}, 64'd0);
        chk("gez_npc", {32'd0, out_npc}, 64'h3008);
        chk("gez_redir", {63'd0, redir_valid}, 64'd0);

        // Same lane, LTZ: taken, redirect raised
        chk_op = c_LTZ; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk("ltz_taken", {63'd0, out_taken}, 64'd1);
        chk("ltz_npc", {32'd0, out_npc}, 64'h3000);
        chk("ltz_redir", {63'd0, redir_valid}, 64'd1);
        chk("ltz_target", {32'd0, redir_target}, 64'h3000);
        chk("ltz_cnt", {48'd0, taken_cnt}, 64'd1);

        // Asynchronous reset mid-redirect, between clock edges
        reset = 1'b1; #2;
        chk("arst_redir", {63'd0, redir_valid}, 64'd0);
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_cnt", {48'd0, taken_cnt}, 64'd0);
        reset = 1'b0; #1;
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        exp_cnt = 0;

        // Stall: first taken op accepted, second held while redir_ready=0
        chk_op = c_LTZ; in_valid = 1'b1; redir_ready = 1'b0;
        tick(); exp_cnt++;
        m_rt = 32'h5000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
            chk("stall_out_valid", {63'd0, out_valid}, 64'd0);
            chk("stall_target", {32'd0, redir_target}, 64'h3000);
        end
        redir_ready = 1'b1; #1;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        tick(); exp_cnt++;
        in_valid = 1'b0; redir_ready = 1'b0;
        chk("release_valid", {63'd0, out_valid}, 64'd1);
        chk("release_redir", {63'd0, redir_valid}, 64'd1);
        chk("release_target", {32'd0, redir_target}, 64'h5000);
        chk("release_cnt", {48'd0, taken_cnt}, 64'd2);
        chk("release_cnt_sat", {62'd0, taken_cnt_s}, 64'd2);
        tick();
        chk("once_out_valid", {63'd0, out_valid}, 64'd0);

        // Back-to-back: hand-off and new taken op in the same cycle
        m_rt = 32'h4000; in_valid = 1'b1; redir_ready = 1'b1;
        tick(); exp_cnt++;
        in_valid = 1'b0;
        chk("b2b_redir", {63'd0, redir_valid}, 64'd1);
        chk("b2b_target", {32'd0, redir_target}, 64'h4000);
        tick();
        chk("b2b_drop", {63'd0, redir_valid}, 64'd0);
        redir_ready = 1'b0;

        // Flush against a would-be taken EQZ
        chk_op = c_EQZ; chk_size = 2'd0; dm_out = '0;
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_redir", {63'd0, redir_valid}, 64'd0);
        chk("flush_cnt", {48'd0, taken_cnt}, 64'd3);

        // Full-width EQ: half 0xFFFF sign-extends to all ones
        redir_ready = 1'b1;
        chk_op = c_EQ; chk_size = 2'd1; addr_lo = 2'd0;
        dm_out = 32'h0000_FFFF; m_cmp = 32'hFFFF_FFFF; m_rt = 32'h6000;
        in_valid = 1'b1;
        tick(); exp_cnt++;
        chk("eq_taken", {63'd0, out_taken}, 64'd1);
        chk("eq_npc", {32'd0, out_npc}, 64'h6000);
        m_cmp = 32'h0000_FFFF;
        tick();
        chk("eq_zx_taken", {63'd0, out_taken}, 64'd0);
        chk("eq_zx_npc", {32'd0, out_npc}, 64'h3008);
        chk("sat_cnt", {62'd0, taken_cnt_s}, 64'd3);

        // Mode/lane table, one op per cycle with redir_ready held high
        for (int i = 0; i < 8; i++) begin
            chk_op = tbl[i].op; chk_size = tbl[i].size;
            addr_lo = tbl[i].lane; dm_out = tbl[i].dm;
            m_rt = 32'h7000 + i * 16; m_pc8 = 32'h8000 + i * 16;
            tick();
            if (tbl[i].taken) exp_cnt++;
            chk($sformatf("tbl%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("tbl%0d_taken", i), {63'd0, out_taken},
                {63'd0, tbl[i].taken});
            chk($sformatf("tbl%0d_npc", i), {32'd0, out_npc},
                tbl[i].taken ? 64'h7000 + i * 16 : 64'h8000 + i * 16);
        end
        in_valid = 1'b0;
        tick();
        chk("end_out_valid", {63'd0, out_valid}, 64'd0);
        chk("end_cnt", {48'd0, taken_cnt}, 64'(exp_cnt));
        chk("end_cnt_sat", {62'd0, taken_cnt_s}, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
